// File: rtl/decode_pipe_pkg.sv
// Shared RV32I/RV64I decode constants, the control-word layout and the
// func3 -> ALU operation mapping used by the decode pipeline.
package decode_pipe_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // ALU-class func3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Memory-access width func3 values
  localparam logic [2:0] F3_MEM_B  = 3'b000;
  localparam logic [2:0] F3_MEM_H  = 3'b001;
  localparam logic [2:0] F3_MEM_W  = 3'b010;
  localparam logic [2:0] F3_MEM_D  = 3'b011;
  localparam logic [2:0] F3_MEM_BU = 3'b100;
  localparam logic [2:0] F3_MEM_HU = 3'b101;
  localparam logic [2:0] F3_MEM_WU = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_t    alu_op;
    logic       alu_src;
    logic       regfile_we;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  // alt selects sub over add and sra over srl; ignored for other func3 values
  function automatic alu_op_t alu_from_func3(input logic [2:0] func3, input logic alt);
    alu_op_t op;
    case (func3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: one instruction word in, one
// control word plus sign-extended immediate out.
module decode_comb
  import decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  output ctrl_t             ctrl,
  output logic [XLEN-1:0]   imm
);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       legal;
  logic       shamt_hi_ok;

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;

  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};

  // Shift-immediate upper bits must be zero apart from bit 30; RV64 has a 6-bit shamt.
  assign shamt_hi_ok = !inst[31] && ((XLEN == 64) ? (inst[29:26] == 4'b0) : (inst[29:25] == 5'b0));

  // NOTE: every output gets a default before the case, so no path leaves a value held (no latch).
  always_comb begin
    ctrl        = '0;
    ctrl.rs1    = inst[19:15];
    ctrl.rs2    = inst[24:20];
    ctrl.rd     = inst[11:7];
    ctrl.alu_op = ALU_ADD;
    imm         = '0;
    legal       = 1'b1;

    case (opcode)
      OPC_OP: begin
        ctrl.regfile_we = 1'b1;
        ctrl.alu_op     = alu_from_func3(func3, func7[5]);
        legal = (func7 == F7_BASE) ||
                ((func7 == F7_ALT) && ((func3 == F3_ADD_SUB) || (func3 == F3_SRL_SRA)));
      end
      OPC_OP_IMM: begin
        ctrl.regfile_we = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = alu_from_func3(func3, (func3 == F3_SRL_SRA) && inst[30]);
        imm             = XLEN'(imm_i);
        case (func3)
          F3_SLL:     legal = shamt_hi_ok && !inst[30];
          F3_SRL_SRA: legal = shamt_hi_ok;
          default:    legal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.regfile_we = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alu_src    = 1'b1;
        imm             = XLEN'(imm_i);
        legal = (func3 == F3_MEM_B) || (func3 == F3_MEM_H) || (func3 == F3_MEM_W) ||
                (func3 == F3_MEM_BU) || (func3 == F3_MEM_HU) ||
                ((XLEN == 64) && ((func3 == F3_MEM_D) || (func3 == F3_MEM_WU)));
      end
      OPC_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alu_src  = 1'b1;
        imm           = XLEN'(imm_s);
        legal = (func3 == F3_MEM_B) || (func3 == F3_MEM_H) || (func3 == F3_MEM_W) ||
                ((XLEN == 64) && (func3 == F3_MEM_D));
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        imm         = XLEN'(imm_b);
        // func3 010/011 are the only undefined branch conditions
        legal = (func3[2:1] != 2'b01);
      end
      OPC_LUI: begin
        ctrl.regfile_we = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_PASSB;
        imm             = XLEN'(imm_u);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl.illegal    = 1'b1;
      ctrl.regfile_we = 1'b0;
      ctrl.memwrite   = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.memtoreg   = 1'b0;
    end
    if (ctrl.rd == 5'd0) ctrl.regfile_we = 1'b0;
  end

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage: decode_comb feeding a two-entry skid buffer so the
// stage sustains one instruction per cycle with a registered in_ready.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0]      inst_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [4:0]             rsa_a_o,
  output logic [4:0]             rsb_a_o,
  output logic [4:0]             rsd_o,
  output logic [XLEN-1:0]        imm_o,
  output logic [3:0]             ALUOp,
  output logic                   ALUSrc,
  output logic                   regfile_we,
  output logic                   memtoreg,
  output logic                   memwrite,
  output logic                   branch,
  output logic                   illegal
);

  typedef struct packed {
    ctrl_t                  ctrl;
    logic [INST_ADDR_W-1:0] pc;
    logic [XLEN-1:0]        imm;
  } entry_t;

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec;
  entry_t          main_q;
  entry_t          skid_q;

  logic main_v_q;
  logic skid_v_q;
  logic in_ready_q;
  logic main_v_d;
  logic skid_v_d;
  logic accept;
  logic drain;
  logic main_from_in;
  logic main_from_skid;
  logic skid_from_in;

  decode_comb #(.XLEN(XLEN)) u_decode (
    .inst (inst_i),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  assign dec    = '{ctrl: dec_ctrl, pc: pc_i, imm: dec_imm};
  assign accept = in_valid && in_ready_q && !flush;
  assign drain  = main_v_q && out_ready;

  always_comb begin
    main_v_d       = main_v_q;
    skid_v_d       = skid_v_q;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || drain) begin
      // Main is free this cycle: the older skid entry always goes first.
      if (skid_v_q) begin
        main_from_skid = 1'b1;
        main_v_d       = 1'b1;
        skid_from_in   = accept;
        skid_v_d       = accept;
      end else begin
        main_from_in = accept;
        main_v_d     = accept;
      end
    end else if (accept) begin
      skid_from_in = 1'b1;
      skid_v_d     = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
      main_q     <= '0;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= !skid_v_d;
      if (main_from_in) begin
        main_q <= dec;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
    end
  end

  // NOTE: skid payload needs no reset; it is never observed unless skid_v_q is set.
  always_ff @(posedge clk) begin
    if (skid_from_in) skid_q <= dec;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_v_q;
  assign pc_o       = main_q.pc;
  assign rsa_a_o    = main_q.ctrl.rs1;
  assign rsb_a_o    = main_q.ctrl.rs2;
  assign rsd_o      = main_q.ctrl.rd;
  assign imm_o      = main_q.imm;
  assign ALUOp      = main_q.ctrl.alu_op;
  assign ALUSrc     = main_q.ctrl.alu_src;
  assign regfile_we = main_q.ctrl.regfile_we;
  assign memtoreg   = main_q.ctrl.memtoreg;
  assign memwrite   = main_q.ctrl.memwrite;
  assign branch     = main_q.ctrl.branch;
  assign illegal    = main_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed test-plan steps followed by
// randomized traffic, all checked against an in-order queue reference model.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic        in_ready, out_valid;
  logic [31:0] pc_o, imm_o;
  logic [4:0]  rsa_a_o, rsb_a_o, rsd_o;
  logic [3:0]  ALUOp;
  logic        ALUSrc, regfile_we, memtoreg, memwrite, branch, illegal;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i), .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .rsa_a_o(rsa_a_o), .rsb_a_o(rsb_a_o), .rsd_o(rsd_o), .imm_o(imm_o),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .regfile_we(regfile_we), .memtoreg(memtoreg),
    .memwrite(memwrite), .branch(branch), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src, we, mtr, mw, br, ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode, written straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    logic [3:0] alu_tab [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int v;
    alu_tab = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    e = '{pc: pc, rs1: inst[19:15], rs2: inst[24:20], rd: inst[11:7], imm: 32'd0,
          alu: 4'd0, src: 1'b0, we: 1'b0, mtr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b0};
    case (opc)
      7'h33: begin
        e.we  = 1'b1;
        e.alu = alu_tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd6;
        if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        e.we = 1'b1; e.src = 1'b1;
        e.alu = alu_tab[f3];
        if (f3 == 3'd5 && inst[30]) e.alu = 4'd7;
        v = (inst[31] ? -2048 : 0) + int'(inst[30:20]);
        e.imm = 32'(v);
        e.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'h03: begin
        e.we = 1'b1; e.mtr = 1'b1; e.src = 1'b1; e.alu = 4'd2;
        v = (inst[31] ? -2048 : 0) + int'(inst[30:20]);
        e.imm = 32'(v);
        e.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'h23: begin
        e.mw = 1'b1; e.src = 1'b1; e.alu = 4'd2;
        v = (inst[31] ? -2048 : 0) + int'(inst[30:25]) * 32 + int'(inst[11:7]);
        e.imm = 32'(v);
        e.ill = (f3 > 3'd2);
      end
      7'h63: begin
        e.br = 1'b1; e.alu = 4'd6;
        v = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 +
            int'(inst[11:8]) * 2;
        e.imm = 32'(v);
        e.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h37: begin
        e.we = 1'b1; e.src = 1'b1; e.alu = 4'd10;
        e.imm = {inst[31:12], 12'h000};
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.we = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.mtr = 1'b0; end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      e = q[0];
      chk("pc_o", pc_o, e.pc);
      chk("rsa", rsa_a_o, e.rs1);
      chk("rsb", rsb_a_o, e.rs2);
      chk("rsd", rsd_o, e.rd);
      chk("illegal", illegal, e.ill);
      chk("regfile_we", regfile_we, e.we);
      chk("memtoreg", memtoreg, e.mtr);
      chk("memwrite", memwrite, e.mw);
      chk("branch", branch, e.br);
      if (!e.ill) begin
        chk("ALUOp", ALUOp, e.alu);
        chk("ALUSrc", ALUSrc, e.src);
        chk("imm", imm_o, e.imm);
      end
    end
  endtask

  // One clock: check the state left by the previous edge, drive, then advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic fl);
    logic acc, drn;
    @(negedge clk);
    check_outputs();
    in_valid = v; pc_i = pc; inst_i = inst; out_ready = rdy; flush = fl;
    acc = v && (q.size() < 2) && !fl;
    drn = (q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(model(pc, inst));
    end
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [7];
    logic [6:0] opc, f7;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h00};
    opc = opcs[$urandom_range(6)];
    if (opc == 7'h00) opc = 7'($urandom);
    case ($urandom_range(3))
      0, 2:    f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(99) < 70, $urandom, rand_inst(), $urandom_range(99) < 60,
           $urandom_range(99) < 5);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_imm", imm_o, 32'h0);
    chk("rst_aluop", ALUOp, 4'h0);
    chk("rst_we", regfile_we, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // add x3,x1,x2
    step(1'b1, 32'h100, 32'h002081B3, 1'b1, 1'b0);
    chk("add_aluop", ALUOp, 4'b0010);
    chk("add_rsa", rsa_a_o, 5'd1);
    chk("add_rsb", rsb_a_o, 5'd2);
    chk("add_rsd", rsd_o, 5'd3);
    chk("add_we", regfile_we, 1'b1);
    chk("add_alusrc", ALUSrc, 1'b0);
    chk("add_illegal", illegal, 1'b0);

    // addi x5,x0,-1 then sub x1,x2,x3 back to back
    step(1'b1, 32'h104, 32'hFFF00293, 1'b1, 1'b0);
    chk("addi_imm", imm_o, 32'hFFFFFFFF);
    chk("addi_alusrc", ALUSrc, 1'b1);
    step(1'b1, 32'h108, 32'h403100B3, 1'b1, 1'b0);
    chk("sub_aluop", ALUOp, 4'b0110);
    chk("sub_valid", out_valid, 1'b1);

    // lw x4,8(x2) then sw x4,12(x2)
    step(1'b1, 32'h10C, 32'h00812203, 1'b1, 1'b0);
    chk("lw_memtoreg", memtoreg, 1'b1);
    chk("lw_imm", imm_o, 32'd8);
    step(1'b1, 32'h110, 32'h00412623, 1'b1, 1'b0);
    chk("sw_memwrite", memwrite, 1'b1);
    chk("sw_we", regfile_we, 1'b0);
    chk("sw_imm", imm_o, 32'd12);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: three offers while execute stalls
    step(1'b1, 32'h200, 32'h002081B3, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'h403100B3, 1'b0, 1'b0);
    chk("hold_in_ready_low", in_ready, 1'b0);
    step(1'b1, 32'h208, 32'hFFF00293, 1'b0, 1'b0);
    chk("hold_pc_stable", pc_o, 32'h200);
    step(1'b1, 32'h208, 32'hFFF00293, 1'b1, 1'b0);
    chk("release_first", pc_o, 32'h204);
    step(1'b1, 32'h208, 32'hFFF00293, 1'b1, 1'b0);
    chk("release_second", pc_o, 32'h208);

    // Flush with both entries full and a new offer
    step(1'b1, 32'h300, 32'h00812203, 1'b0, 1'b0);
    chk("flush_setup_full", in_ready, 1'b0);
    step(1'b1, 32'h304, 32'h00412623, 1'b1, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Illegal zero word, then the canonical nop
    step(1'b1, 32'h400, 32'h00000000, 1'b1, 1'b0);
    chk("zero_illegal", illegal, 1'b1);
    chk("zero_we", regfile_we, 1'b0);
    step(1'b1, 32'h404, 32'h00000013, 1'b1, 1'b0);
    chk("nop_illegal", illegal, 1'b0);
    chk("nop_we", regfile_we, 1'b0);

    random_traffic(600);

    // Asynchronous reset in the middle of traffic
    step(1'b1, 32'h500, 32'h002081B3, 1'b0, 1'b0);
    step(1'b1, 32'h504, 32'h00812203, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_pc_o", pc_o, 32'h0);
    chk("mid_rst_memtoreg", memtoreg, 1'b0);
    q.delete();
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    random_traffic(300);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
